mem_port_arbiter: RTL

Shares the single-port main memory between the processor control/datapath (instruction fetch in P1, LD/ST in P4) and the external program loader/debug port. Fixed core priority with a loader starvation guard and a bounded loader lock for burst program download. Sits between the control unit's memory strobes and the synchronous RAM macro, and routes read data back to the winning requester.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the main-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W     = 12;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_STARVE_LIM = 8;
    localparam int unsigned DEF_BURST_MAX  = 16;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the core (fetch / LD-ST) and the program
// loader. Core has fixed priority, the loader is protected by a starvation
// counter and may lock the port for a bounded burst.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM,
    parameter int unsigned BURST_MAX  = DEF_BURST_MAX
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIM + 1);
    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIM);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    arb_state_t        r_state, w_state_nxt;
    logic [SW-1:0]     r_starve_cnt, w_starve_nxt;
    logic [BW-1:0]     r_burst_cnt, w_burst_nxt;
    logic              r_forced, w_forced_nxt;
    owner_t            w_win;

    logic              r_core_gnt, r_ldr_gnt;
    logic              r_ram_en, r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    owner_t            r_rd_owner, r_ret_owner;
    logic [DATA_W-1:0] r_core_rdata, r_ldr_rdata;
    logic              w_core_rvalid, w_ldr_rvalid;

    // Winner selection, lock/burst bookkeeping and starvation counting.
    always_comb begin
        w_win        = OWN_NONE;
        w_state_nxt  = r_state;
        w_burst_nxt  = r_burst_cnt;
        w_forced_nxt = 1'b0;
        w_starve_nxt = '0;
        if (r_state == LOCKED) begin
            if (!ldr_req) begin
                w_state_nxt = FREE;
                w_burst_nxt = '0;
            end else begin
                w_win = OWN_LDR;
                if (!ldr_lock) begin
                    w_state_nxt = FREE;
                    w_burst_nxt = '0;
                end else if (r_burst_cnt == BURST_LAST) begin
                    // burst limit reached: hand the following slot to the core
                    w_state_nxt  = FREE;
                    w_burst_nxt  = '0;
                    w_forced_nxt = 1'b1;
                end else begin
                    w_burst_nxt = r_burst_cnt + BW'(1);
                end
            end
        end else begin
            if (r_forced) begin
                if (core_req)     w_win = OWN_CORE;
                else if (ldr_req) w_win = OWN_LDR;
            end else if (ldr_req && (r_starve_cnt == STARVE_TOP)) begin
                w_win = OWN_LDR;
            end else if (core_req) begin
                w_win = OWN_CORE;
            end else if (ldr_req) begin
                w_win = OWN_LDR;
            end
            // a fallback grant in the forced-release slot never re-locks
            if ((w_win == OWN_LDR) && ldr_lock && !r_forced) begin
                if (BURST_MAX == 1) begin
                    w_forced_nxt = 1'b1;
                end else begin
                    w_state_nxt = LOCKED;
                    w_burst_nxt = BW'(1);
                end
            end
        end
        if (ldr_req && (w_win != OWN_LDR)) begin
            w_starve_nxt = (r_starve_cnt == STARVE_TOP) ? r_starve_cnt
                                                        : r_starve_cnt + SW'(1);
        end
    end

    // Arbiter state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FREE;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
            r_forced     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_forced     <= w_forced_nxt;
        end
    end

    // Registered RAM command and grant pulses from the winning requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_gnt  <= 1'b0;
            r_ldr_gnt   <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_core_gnt <= (w_win == OWN_CORE);
            r_ldr_gnt  <= (w_win == OWN_LDR);
            r_ram_en   <= (w_win != OWN_NONE);
            case (w_win)
                OWN_CORE: begin
                    r_ram_we    <= core_we;
                    r_ram_addr  <= core_addr;
                    r_ram_wdata <= core_wdata;
                end
                OWN_LDR: begin
                    r_ram_we    <= ldr_we;
                    r_ram_addr  <= ldr_addr;
                    r_ram_wdata <= ldr_wdata;
                end
                default: r_ram_we <= 1'b0;
            endcase
        end
    end

    // Read-owner tag follows the access into the RAM data cycle; rdata holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_owner   <= OWN_NONE;
            r_ret_owner  <= OWN_NONE;
            r_core_rdata <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            if ((w_win == OWN_CORE) && !core_we)     r_rd_owner <= OWN_CORE;
            else if ((w_win == OWN_LDR) && !ldr_we)  r_rd_owner <= OWN_LDR;
            else                                     r_rd_owner <= OWN_NONE;
            r_ret_owner <= r_rd_owner;
            if (w_core_rvalid) r_core_rdata <= ram_rdata;
            if (w_ldr_rvalid)  r_ldr_rdata  <= ram_rdata;
        end
    end

    assign w_core_rvalid = (r_ret_owner == OWN_CORE);
    assign w_ldr_rvalid  = (r_ret_owner == OWN_LDR);

    assign core_gnt    = r_core_gnt;
    assign ldr_gnt     = r_ldr_gnt;
    assign core_rvalid = w_core_rvalid;
    assign ldr_rvalid  = w_ldr_rvalid;
    assign core_rdata  = w_core_rvalid ? ram_rdata : r_core_rdata;
    assign ldr_rdata   = w_ldr_rvalid  ? ram_rdata : r_ldr_rdata;
    assign ram_en      = r_ram_en;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;

endmodule
